gpio_port: RTL and testbench
============================

# gpio_port

Parametrised multi-pin GPIO port: the next generation of the single-pin GPIO cell. Each of WIDTH pins has its own direction and output value and a synchronised, optionally debounced input path. Inputs get per-pin edge-interrupt detection with sticky, write-1-to-clear status and one aggregated interrupt line. The block sits between the register/bus interface and the top-level pad tristate buffers. Tristates are instantiated at top level only.

## Interface
- WIDTH, 8: number of pins, 1..32.
- SYNC_STAGES, 2: input synchroniser depth, ≥2.
- DEBOUNCE_CYCLES, 4: cycles a new level must stay stable before it is accepted; 0 bypasses debounce.

- clk  in  1  port clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable_n  in  1  port enable, active low.
- dir  in  WIDTH  per pin: 1 = output, 0 = input.
- data_out  in  WIDTH  value driven on output pins.
- irq_enable  in  WIDTH  per-pin interrupt enable.
- int_mode  in  2*WIDTH  per pin, 2 bits: 00 off, 01 rising, 10 falling, 11 any edge.
- irq_clear  in  WIDTH  write-1-to-clear pulse for irq_status.
- pad_in  in  WIDTH  raw pad levels, asynchronous.
- pad_out  out  WIDTH  registered output data to the pads.
- pad_oe  out  WIDTH  registered output enables to the pads.
- data_in  out  WIDTH  filtered pad level.
- irq_status  out  WIDTH  sticky per-pin edge flags.
- irq  out  1  `|(irq_status & irq_enable)`, decoded from flops only.

## Operation
- **Reset (reset_n low, asynchronous):** all flops clear. pad_out, pad_oe, data_in, irq_status and irq are all 0. Synchroniser stages, stable levels, debounce counters and edge "prev" registers are also 0.
- **Output path:** each cycle, pad_out ← data_out and pad_oe ← dir & {WIDTH{~enable_n}}.
- **Input path, per pin:** SYNC_STAGES flop chain, then debounce filter.
  - Each pin has a stable level and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - When the synced value differs from stable, the counter increments. When it matches, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES, stable takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
  - With DEBOUNCE_CYCLES = 0, stable follows synced directly.
- **data_in:** equals stable while enable_n = 0, and 0 while enable_n = 1. Output pins read back their own pad.
- **Edge detection:** prev ← stable every cycle.
  - rise = stable & ~prev; fall = ~stable & prev.
  - An edge qualifies per int_mode, and only if dir = 0 and enable_n = 0.
- **irq_status:** set by a qualifying edge, cleared by irq_clear. If set and clear hit the same bit in the same cycle, set wins. irq_enable masks only irq, not irq_status.
- **Direction change:** in any cycle where a pin's dir bit differs from its registered copy, edge qualification for that pin is suppressed. A turnaround therefore never raises a flag.
- **enable_n = 1:**
  - pad_oe is all 0 from the next cycle.
  - irq_status is cleared and irq is 0.
  - Filters keep tracking pad_in, so re-enabling produces no stale edge.
  - Edge qualification is suppressed in the first cycle after enable_n falls.
- **int_mode change** takes effect on the next cycle and never generates a flag by itself.

## Timing
- data_out/dir to pad_out/pad_oe: 1 cycle.
- pad_in step to data_in:
  - SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles when DEBOUNCE_CYCLES > 0.
  - SYNC_STAGES + 1 cycles when bypassed.
- stable change to irq_status set: 1 cycle. irq follows irq_status in the same cycle (no added latency).
- irq_clear pulse to irq_status bit 0: 1 cycle.
- Back-to-back edges on one pin with no clear: status stays 1. Edges are not counted.
- Reset asserted mid-debounce: counter and stable clear immediately. After release, a pad held at 1 is reported as a rising edge once filtered, if enabled.

## Structure
- Package gpio_pkg holds:
  - the int_mode localparams INT_OFF = 2'b00, INT_RISE = 2'b01, INT_FALL = 2'b10, INT_ANY = 2'b11;
  - the function for debounce counter width.
- Sub-module gpio_pin_filter (synchroniser + debounce, one pin, parameters SYNC_STAGES and DEBOUNCE_CYCLES) is instantiated WIDTH times with a generate loop.
- Edge detection, status and output registers stay in gpio_port.

## Test plan
- **Reset:** hold reset_n low with pad_in = 8'hFF and data_out = 8'hAA. All outputs read 0. After release and 8 idle cycles with dir = 0, data_in = 8'hFF and irq_status = 8'hFF only if int_mode = 01.
- **Output:** dir = 8'h0F, data_out = 8'h05, enable_n = 0. pad_oe = 8'h0F and pad_out = 8'h05 one cycle later. data_in[3:0] = 4'h5 after filter latency. No irq_status bits set.
- **Debounce:** DEBOUNCE_CYCLES = 4. A 3-cycle high glitch on pin 2 leaves data_in[2] at 0 and no flag. A 5-cycle high sets data_in[2] at cycle 2+4+1. With int_mode[5:4] = 01, irq_status[2] = 1 one cycle later.
- **Modes:** pin 0 = rise, pin 1 = fall, pin 2 = any. Pulse each pin 0→1→0. Final status is pin 0 = 1, pin 1 = 1, pin 2 = 1. irq = 1 only where irq_enable is set.
- **Clear collision:** assert irq_clear[3] in the same cycle a new edge on pin 3 qualifies. irq_status[3] stays 1. A second clear alone gives 0 and irq drops.
- **Turnaround / disable:** flip pin 4 dir 1→0 with the pad at the opposite level. No flag is raised. Pulse enable_n high for 3 cycles: pad_oe = 0, irq_status = 0. Re-enable: no spurious flags.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared definitions for the multi-pin GPIO port: interrupt mode encodings,
// debounce counter sizing and the per-pin edge-mode decode.
package gpio_pkg;

    localparam logic [1:0] INT_OFF  = 2'b00;
    localparam logic [1:0] INT_RISE = 2'b01;
    localparam logic [1:0] INT_FALL = 2'b10;
    localparam logic [1:0] INT_ANY  = 2'b11;

    // Width of a counter that must hold the value 'cycles'; never below 1 bit.
    function automatic int dbc_cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

    // True when an observed rise/fall matches the pin's interrupt mode.
    function automatic logic edge_hit(input logic [1:0] mode, input logic rise, input logic fall);
        logic hit;
        case (mode)
            INT_RISE: hit = rise;
            INT_FALL: hit = fall;
            INT_ANY:  hit = rise | fall;
            INT_OFF:  hit = 1'b0;
            default:  hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/gpio_pin_filter.sv
// One pin's input path: a SYNC_STAGES flop synchroniser followed by a
// debounce filter that only accepts a level held for longer than
// DEBOUNCE_CYCLES synchronised samples (or passes straight through at 0).
module gpio_pin_filter
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pad_i,
    output logic stable_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   stable_q;

    // Shift the asynchronous pad level through the synchroniser chain.
    // NOTE: every sequential block uses non-blocking (<=) assignments so all
    // flops sample pre-edge values; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        // Without debounce the stable level is just the synchronised level.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stable_q <= 1'b0;
            end else begin
                stable_q <= synced;
            end
        end
    end else begin : g_debounce
        localparam int             CW      = dbc_cnt_width(DEBOUNCE_CYCLES);
        localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

        logic [CW-1:0] cnt_q;

        // Count consecutive differing samples; accept the new level once the
        // count has reached DEBOUNCE_CYCLES and the difference persists.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stable_q <= 1'b0;
                cnt_q    <= '0;
            end else if (synced != stable_q) begin
                if (cnt_q == CNT_MAX) begin
                    stable_q <= synced;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/gpio_port.sv
// WIDTH-pin GPIO port: registered output/enable path to the pad tristates,
// filtered input path, and per-pin sticky edge interrupts aggregated to irq.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable_n,
    input  logic [WIDTH-1:0]   dir,
    input  logic [WIDTH-1:0]   data_out,
    input  logic [WIDTH-1:0]   irq_enable,
    input  logic [2*WIDTH-1:0] int_mode,
    input  logic [WIDTH-1:0]   irq_clear,
    input  logic [WIDTH-1:0]   pad_in,
    output logic [WIDTH-1:0]   pad_out,
    output logic [WIDTH-1:0]   pad_oe,
    output logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   irq_status,
    output logic               irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] pad_out_q;
    logic [WIDTH-1:0] pad_oe_q;
    logic [WIDTH-1:0] irq_status_q;
    logic [WIDTH-1:0] irq_status_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_gate;
    logic [WIDTH-1:0] qual;
    logic             en_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_pin_filter #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_filter (
            .clk      (clk),
            .reset_n  (reset_n),
            .pad_i    (pad_in[i]),
            .stable_o (stable[i])
        );
    end

    assign rise = stable & ~prev_q;
    assign fall = ~stable & prev_q;

    // An edge may only count on an input pin whose direction did not just
    // change, while enabled and not in the first cycle after re-enable.
    assign edge_gate = ~dir & ~(dir ^ dir_q) & {WIDTH{~enable_n & en_q}};

    // Decode each pin's qualifying edge from its interrupt mode.
    // NOTE: qual gets a full default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        qual = '0;
        for (int i = 0; i < WIDTH; i++) begin
            qual[i] = edge_gate[i] & edge_hit(int_mode[2*i +: 2], rise[i], fall[i]);
        end
    end

    // Set beats clear on the same bit; disabling the port wipes all flags.
    assign irq_status_d = enable_n ? '0 : ((irq_status_q & ~irq_clear) | qual);

    // Register outputs, edge history, direction copy, enable history and status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pad_out_q    <= '0;
            pad_oe_q     <= '0;
            prev_q       <= '0;
            dir_q        <= '0;
            en_q         <= 1'b0;
            irq_status_q <= '0;
        end else begin
            pad_out_q    <= data_out;
            pad_oe_q     <= dir & {WIDTH{~enable_n}};
            prev_q       <= stable;
            dir_q        <= dir;
            en_q         <= ~enable_n;
            irq_status_q <= irq_status_d;
        end
    end

    assign pad_out    = pad_out_q;
    assign pad_oe     = pad_oe_q;
    assign data_in    = enable_n ? '0 : stable;
    assign irq_status = irq_status_q;
    assign irq        = |(irq_status_q & irq_enable);

endmodule

// File: tb/tb_gpio_port.sv
// Bench for gpio_port: a debounced instance (SYNC 2, DEBOUNCE 4) and a
// bypassed one (SYNC 3, DEBOUNCE 0) share stimulus and are compared every
// cycle against a sliding-window reference model, plus directed sequences.
module tb_gpio_port;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable_n = 1'b0;
    logic [7:0]  dir = '0;
    logic [7:0]  data_out = '0;
    logic [7:0]  irq_enable = '0;
    logic [15:0] int_mode = '0;
    logic [7:0]  irq_clear = '0;
    logic [7:0]  pad_in = '0;

    logic [7:0]  pad_out_a, pad_oe_a, data_in_a, irq_status_a;
    logic        irq_a;
    logic [7:0]  pad_out_b, pad_oe_b, data_in_b, irq_status_b;
    logic        irq_b;

    gpio_port #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable_n(enable_n), .dir(dir),
        .data_out(data_out), .irq_enable(irq_enable), .int_mode(int_mode),
        .irq_clear(irq_clear), .pad_in(pad_in), .pad_out(pad_out_a),
        .pad_oe(pad_oe_a), .data_in(data_in_a), .irq_status(irq_status_a),
        .irq(irq_a)
    );

    gpio_port #(.WIDTH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable_n(enable_n), .dir(dir),
        .data_out(data_out), .irq_enable(irq_enable), .int_mode(int_mode),
        .irq_clear(irq_clear), .pad_in(pad_in), .pad_out(pad_out_b),
        .pad_oe(pad_oe_b), .data_in(data_in_b), .irq_status(irq_status_b),
        .irq(irq_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] stable;
        logic [7:0] prev;
        logic [7:0] status;
    } mstate_t;

    mstate_t    ma, mb;
    logic [7:0] hist [0:15];   // hist[k] = pad_in sampled k edges ago
    logic [7:0] dir_prev = '0;
    logic       en_prev = 1'b0;
    logic [7:0] m_pad_out = '0;
    logic [7:0] m_pad_oe = '0;

    // A level is accepted once the last dc+1 synchronised samples all agree.
    function automatic logic [7:0] filt(input logic [7:0] cur, input int s, input int dc);
        logic [7:0] r;
        logic       v;
        logic       same;
        r = cur;
        for (int b = 0; b < 8; b++) begin
            v = hist[s][b];
            same = 1'b1;
            for (int j = s; j <= s + dc; j++) begin
                if (hist[j][b] != v) same = 1'b0;
            end
            if (same) r[b] = v;
        end
        return r;
    endfunction

    function automatic mstate_t mstep(input mstate_t m, input int s, input int dc);
        mstate_t    n;
        logic [7:0] q;
        logic       r, f;
        q = '0;
        for (int b = 0; b < 8; b++) begin
            if (!dir[b] && !dir_prev[b] && !enable_n && en_prev) begin
                r = m.stable[b] && !m.prev[b];
                f = !m.stable[b] && m.prev[b];
                q[b] = (int_mode[2*b] && r) || (int_mode[2*b+1] && f);
            end
        end
        n.status = enable_n ? 8'h00 : ((m.status & ~irq_clear) | q);
        n.prev   = m.stable;
        n.stable = filt(m.stable, s, dc);
        return n;
    endfunction

    task automatic compare_model();
        check("a_pad_out", pad_out_a, m_pad_out);
        check("a_pad_oe", pad_oe_a, m_pad_oe);
        check("a_data_in", data_in_a, enable_n ? 8'h00 : ma.stable);
        check("a_irq_status", irq_status_a, ma.status);
        check("a_irq", irq_a, |(ma.status & irq_enable));
        check("b_pad_out", pad_out_b, m_pad_out);
        check("b_pad_oe", pad_oe_b, m_pad_oe);
        check("b_data_in", data_in_b, enable_n ? 8'h00 : mb.stable);
        check("b_irq_status", irq_status_b, mb.status);
        check("b_irq", irq_b, |(mb.status & irq_enable));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then
    // compare both DUTs shortly after the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            for (int k = 0; k < 16; k++) hist[k] = '0;
            ma = '{default: '0};
            mb = '{default: '0};
            dir_prev  = '0;
            en_prev   = 1'b0;
            m_pad_out = '0;
            m_pad_oe  = '0;
        end else begin
            for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = pad_in;
            ma = mstep(ma, 2, 4);
            mb = mstep(mb, 3, 0);
            m_pad_out = data_out;
            m_pad_oe  = dir & {8{~enable_n}};
            dir_prev  = dir;
            en_prev   = ~enable_n;
        end
        #1;
        compare_model();
    endtask

    typedef struct {
        logic       en_n;
        logic [7:0] dir;
        logic [7:0] dout;
        logic [7:0] exp_out;
        logic [7:0] exp_oe;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{1'b0, 8'h0F, 8'h05, 8'h05, 8'h0F};
        vecs[1] = '{1'b0, 8'hFF, 8'hA5, 8'hA5, 8'hFF};
        vecs[2] = '{1'b1, 8'hFF, 8'h3C, 8'h3C, 8'h00};
        vecs[3] = '{1'b0, 8'hF0, 8'hC3, 8'hC3, 8'hF0};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00};

        // ---- reset ----
        pad_in = 8'hFF; data_out = 8'hAA; int_mode = 16'h5555; dir = '0;
        repeat (3) tick();
        check("rst_pad_out", pad_out_a, 8'h00);
        check("rst_pad_oe", pad_oe_a, 8'h00);
        check("rst_data_in", data_in_a, 8'h00);
        check("rst_irq_status", irq_status_a, 8'h00);
        check("rst_irq", irq_a, 1'b0);
        reset_n = 1'b1;
        repeat (7) tick();
        check("rst_rel_data_in", data_in_a, 8'hFF);
        check("rst_rel_status_early", irq_status_a, 8'h00);
        tick();
        check("rst_rel_status", irq_status_a, 8'hFF);
        check("rst_rel_irq_masked", irq_a, 1'b0);
        irq_enable = 8'h01;
        tick();
        check("rst_rel_irq", irq_a, 1'b1);
        irq_clear = 8'hFF; int_mode = '0; irq_enable = '0;
        tick();
        irq_clear = '0;
        check("clear_all", irq_status_a, 8'h00);

        // ---- output path table ----
        for (int i = 0; i < 5; i++) begin
            enable_n = vecs[i].en_n; dir = vecs[i].dir; data_out = vecs[i].dout;
            tick();
            check($sformatf("vec%0d_pad_out", i), pad_out_a, vecs[i].exp_out);
            check($sformatf("vec%0d_pad_oe", i), pad_oe_a, vecs[i].exp_oe);
        end
        dir = 8'h0F; data_out = 8'h05; pad_in = 8'h05;
        repeat (7) tick();
        check("out_readback", data_in_a[3:0], 4'h5);
        check("out_no_status", irq_status_a, 8'h00);

        // ---- debounce on pin 2 ----
        dir = '0; data_out = '0; pad_in = '0; int_mode = 16'h0010;
        repeat (10) tick();
        pad_in = 8'h04;
        repeat (3) tick();
        pad_in = 8'h00;
        repeat (10) tick();
        check("glitch_data_in", data_in_a, 8'h00);
        check("glitch_status", irq_status_a, 8'h00);
        pad_in = 8'h04;
        repeat (5) tick();
        pad_in = 8'h00;
        tick();
        check("dbnc_lat_minus1", data_in_a, 8'h00);
        tick();
        check("dbnc_lat", data_in_a, 8'h04);
        check("dbnc_status_early", irq_status_a, 8'h00);
        tick();
        check("dbnc_status", irq_status_a, 8'h04);
        repeat (10) tick();
        irq_clear = 8'hFF; tick(); irq_clear = '0;

        // ---- interrupt modes ----
        int_mode = 16'h0039; irq_enable = 8'h05; pad_in = 8'h07;
        repeat (8) tick();
        check("mode_after_rise", irq_status_a, 8'h05);
        pad_in = 8'h00;
        repeat (8) tick();
        check("mode_after_fall", irq_status_a, 8'h07);
        check("mode_irq", irq_a, 1'b1);
        irq_enable = 8'h08;
        tick();
        check("mode_irq_masked", irq_a, 1'b0);
        irq_clear = 8'hFF; tick(); irq_clear = '0;

        // ---- set/clear collision on pin 3 ----
        int_mode = 16'h0040; irq_enable = 8'h08; pad_in = 8'h08;
        repeat (8) tick();
        check("clr_first_edge", irq_status_a, 8'h08);
        check("clr_irq_high", irq_a, 1'b1);
        pad_in = 8'h00;
        repeat (10) tick();
        pad_in = 8'h08;
        repeat (7) tick();
        irq_clear = 8'h08;
        tick();
        irq_clear = '0;
        check("clr_collision", irq_status_a, 8'h08);
        tick();
        irq_clear = 8'h08;
        tick();
        irq_clear = '0;
        check("clr_alone", irq_status_a, 8'h00);
        check("clr_irq_low", irq_a, 1'b0);

        // ---- turnaround on pin 4 ----
        int_mode = 16'h0300; irq_enable = 8'h10; dir = 8'h10; pad_in = 8'h00;
        repeat (10) tick();
        pad_in = 8'h10;
        repeat (7) tick();
        dir = 8'h00;
        repeat (5) tick();
        check("turnaround_status", irq_status_a, 8'h00);
        check("turnaround_data_in", data_in_a, 8'h10);

        // ---- disable / re-enable ----
        dir = 8'hE0; pad_in = 8'h00;
        repeat (8) tick();
        check("fall_pin4", irq_status_a, 8'h10);
        repeat (2) tick();
        pad_in = 8'h10;
        repeat (4) tick();
        enable_n = 1'b1;
        tick();
        check("dis_pad_oe", pad_oe_a, 8'h00);
        check("dis_status", irq_status_a, 8'h00);
        check("dis_irq", irq_a, 1'b0);
        check("dis_data_in", data_in_a, 8'h00);
        repeat (2) tick();
        enable_n = 1'b0;
        repeat (5) tick();
        check("reen_no_flag", irq_status_a, 8'h00);
        check("reen_data_in", data_in_a, 8'h10);
        check("reen_pad_oe", pad_oe_a, 8'hE0);

        // ---- randomized run against the model ----
        int_mode = 16'hFFFF; dir = '0;
        repeat (2000) begin
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                tick();
                tick();
                reset_n = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) pad_in = pad_in ^ (8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) dir = 8'($urandom);
            if ($urandom_range(0, 39) == 0) enable_n = ~enable_n;
            if ($urandom_range(0, 99) == 0) int_mode = 16'($urandom);
            irq_clear  = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h00;
            irq_enable = 8'($urandom);
            data_out   = 8'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
